// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT/BTB branch predictor with a post-reset init sweep, registered
// mispredict/redirect and statistics. Define BP_GSHARE_EN to index counters by pc XOR GHR.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | sweep table (valid=0, ctr=INIT_CTR), predictions and updates ignored
// ST_RUN  | table valid; lookups predict, updates train, stats count
module branch_predictor_bht #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 8,
    parameter logic [1:0]  INIT_CTR   = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_predicted,
    input  logic [31:0] update_pred_target,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    output logic [31:0] lookup_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q;

    logic [DEPTH-1:0]      valid_q;
    logic [1:0]            ctr_q    [DEPTH];
    logic [TAG_BITS-1:0]   tag_q    [DEPTH];
    logic [31:0]           target_q [DEPTH];

    logic [INDEX_BITS-1:0] lk_idx, lk_cidx, up_idx, up_cidx;
    logic [TAG_BITS-1:0]   lk_tag, up_tag;
    logic                  run, lk_hit, up_hit, mis_det;
    logic [1:0]            up_ctr, up_ctr_next;
    logic                  unused_lookup_bits;

    assign lk_idx = lookup_pc[INDEX_BITS+1:2];
    assign lk_tag = lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign up_idx = update_pc[INDEX_BITS+1:2];
    assign up_tag = update_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign unused_lookup_bits = ^{lookup_pc[1:0], lookup_pc[31:INDEX_BITS+TAG_BITS+2]};

`ifdef BP_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q;

    always_ff @(posedge clk) begin
        if (reset || state_q == ST_INIT) begin
            ghr_q <= '0;
        end else if (update_valid) begin
            ghr_q <= {ghr_q[INDEX_BITS-2:0], update_taken};
        end
    end

    assign lk_cidx = lk_idx ^ ghr_q;
    assign up_cidx = up_idx ^ ghr_q;
`else
    assign lk_cidx = lk_idx;
    assign up_cidx = up_idx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= (state_q == ST_INIT) ? ptr_q + 1'b1 : ptr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (ptr_q == '1) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign run   = (state_q == ST_RUN);
    assign ready = run;

    // Reads see only registered table contents: no bypass of a same-cycle update.
    assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign predict_taken  = run && lk_hit && ctr_q[lk_cidx][1];
    assign predict_target = predict_taken ? target_q[lk_idx] : 32'h0;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr = ctr_q[up_cidx];

    always_comb begin
        up_ctr_next = up_ctr;
        if (update_taken) begin
            if (up_ctr != 2'b11) up_ctr_next = up_ctr + 2'd1;
        end else begin
            if (up_ctr != 2'b00) up_ctr_next = up_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                valid_q[ptr_q] <= 1'b0;
                ctr_q[ptr_q]   <= INIT_CTR;
            end else if (update_valid) begin
                if (up_hit) begin
                    ctr_q[up_cidx] <= up_ctr_next;
                    if (update_taken) target_q[up_idx] <= update_target;
                end else if (update_taken) begin
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= update_target;
                    ctr_q[up_cidx]   <= 2'b10;
                end
            end
        end
    end

    assign mis_det = (update_predicted != update_taken) ||
                     (update_taken && update_predicted && (update_pred_target != update_target));

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict       <= 1'b0;
            correct_pc       <= 32'h0;
            lookup_count     <= 32'h0;
            mispredict_count <= 32'h0;
        end else begin
            mispredict <= run && update_valid && mis_det;
            if (run && update_valid && mis_det) begin
                correct_pc <= update_taken ? update_target : update_pc + 32'd4;
                if (mispredict_count != 32'hFFFF_FFFF) mispredict_count <= mispredict_count + 32'd1;
            end
            if (run && lookup_valid && lookup_count != 32'hFFFF_FFFF) begin
                lookup_count <= lookup_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed scenarios plus randomized
// traffic compared every cycle against a behavioural table model.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_predicted;
    logic [31:0] update_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] lookup_count;
    logic [31:0] mispredict_count;

    branch_predictor_bht dut (
        .clk(clk), .reset(reset), .ready(ready),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_predicted(update_predicted), .update_pred_target(update_pred_target),
        .mispredict(mispredict), .correct_pc(correct_pc),
        .lookup_count(lookup_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: 64 entries, counters held as plain integers 0..3
    bit          m_valid [64];
    int          m_ctr   [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          init_left;
    bit          m_misp;
    logic [31:0] m_cpc;
    logic [31:0] m_lc;
    logic [31:0] m_mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_pred(output bit pt, output logic [31:0] tg);
        int i;
        i  = int'(lookup_pc[7:2]);
        pt = (init_left == 0) && m_valid[i] && (m_tag[i] == int'(lookup_pc[15:8])) && (m_ctr[i] >= 2);
        tg = pt ? m_tgt[i] : 32'h0;
    endtask

    task automatic model_update();
        int i;
        bit hit, wrong;
        if (reset) begin
            init_left = 64;
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_misp = 1'b0; m_cpc = 32'h0; m_lc = 32'h0; m_mc = 32'h0;
        end else if (init_left > 0) begin
            init_left--;
            m_misp = 1'b0;
        end else begin
            wrong  = update_valid && ((update_predicted != update_taken) ||
                     (update_predicted && update_taken && update_pred_target != update_target));
            m_misp = wrong;
            if (wrong) begin
                m_cpc = update_taken ? update_target : update_pc + 32'd4;
                if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
            end
            if (lookup_valid && m_lc != 32'hFFFF_FFFF) m_lc = m_lc + 1;
            if (update_valid) begin
                i   = int'(update_pc[7:2]);
                hit = m_valid[i] && (m_tag[i] == int'(update_pc[15:8]));
                if (hit) begin
                    m_ctr[i] = update_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                            : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                    if (update_taken) m_tgt[i] = update_target;
                end else if (update_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = int'(update_pc[15:8]);
                    m_tgt[i]   = update_target;
                    m_ctr[i]   = 2;
                end
            end
        end
    endtask

    task automatic step(input bit do_check);
        bit          pt;
        logic [31:0] tg;
        @(negedge clk);
        if (do_check) begin
            model_pred(pt, tg);
            chk("ready", 32'(ready), 32'(init_left == 0));
            chk("predict_taken", 32'(predict_taken), 32'(pt));
            chk("predict_target", predict_target, tg);
            chk("mispredict", 32'(mispredict), 32'(m_misp));
            chk("correct_pc", correct_pc, m_cpc);
            chk("lookup_count", lookup_count, m_lc);
            chk("mispredict_count", mispredict_count, m_mc);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        lookup_valid = 1'b0; lookup_pc = 32'h0;
        update_valid = 1'b0; update_pc = 32'h0; update_taken = 1'b0;
        update_target = 32'h0; update_predicted = 1'b0; update_pred_target = 32'h0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_valid = 1'b1; lookup_pc = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                       input bit pr, input logic [31:0] ptgt);
        update_valid = 1'b1; update_pc = pc; update_taken = tk;
        update_target = tgt; update_predicted = pr; update_pred_target = ptgt;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = 32'h0;
        pc[15:8] = 8'($urandom_range(0, 1));
        pc[7:2]  = 6'($urandom_range(0, 7));
        return pc;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = 32'h1000 * 32'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;

        // INIT: random traffic must be ignored for 64 cycles
        for (int n = 0; n < 64; n++) begin
            look($urandom());
            upd(rand_pc(), 1'(($urandom() & 1)), rand_tgt(), 1'b0, 32'h0);
            step(1'b1);
        end
        idle();
        step(1'b1);
        chk("ready_after_init", 32'(ready), 32'd1);
        chk("lookup_count_init", lookup_count, 32'd0);

        // allocate 0x40, then predicted taken next cycle
        upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        step(1'b1);
        idle(); look(32'h40); #1;
        chk("alloc_taken", 32'(predict_taken), 32'd1);
        chk("alloc_target", predict_target, 32'h100);
        step(1'b1);

        for (int n = 0; n < 2; n++) begin
            idle(); upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0); step(1'b1);
        end
        idle(); look(32'h40); #1;
        chk("two_nt", 32'(predict_taken), 32'd0);
        step(1'b1);
        for (int n = 0; n < 5; n++) begin
            idle(); upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); step(1'b1);
        end
        idle(); upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0); step(1'b1);
        idle(); look(32'h40); #1;
        chk("sat_hi_then_nt", 32'(predict_taken), 32'd1);
        step(1'b1);

        // mispredicts on 0x80
        idle(); upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
        step(1'b1);
        chk("misp_pulse", 32'(mispredict), 32'd1);
        chk("misp_cpc_taken", correct_pc, 32'h200);
        chk("misp_count1", mispredict_count, 32'd1);
        idle(); upd(32'h80, 1'b0, 32'h0, 1'b1, 32'h200);
        step(1'b1);
        chk("misp_cpc_nt", correct_pc, 32'h84);
        chk("misp_count2", mispredict_count, 32'd2);
        idle();
        step(1'b1);
        chk("misp_one_cycle", 32'(mispredict), 32'd0);
        chk("cpc_held", correct_pc, 32'h84);

        // same-cycle lookup and allocate: no bypass
        upd(32'hC0, 1'b1, 32'h300, 1'b1, 32'h300); look(32'hC0); #1;
        chk("no_bypass", 32'(predict_taken), 32'd0);
        step(1'b1);
        idle(); look(32'hC0); #1;
        chk("after_alloc", 32'(predict_taken), 32'd1);
        chk("after_alloc_tgt", predict_target, 32'h300);
        step(1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 3) != 0) look(rand_pc());
            if ($urandom_range(0, 2) != 0) begin
                logic [31:0] t;
                t = rand_tgt();
                upd(rand_pc(), 1'(($urandom() & 1)), t, 1'(($urandom() & 1)),
                    ($urandom_range(0, 1) != 0) ? t : rand_tgt());
            end
            step(1'b1);
        end

        // reset mid-sweep at ptr=30
        idle(); reset = 1'b1; step(1'b1);
        reset = 1'b0;
        for (int n = 0; n < 30; n++) begin
            look(rand_pc()); step(1'b1);
        end
        reset = 1'b1; step(1'b1);
        reset = 1'b0;
        chk("midsweep_lcount", lookup_count, 32'd0);
        chk("midsweep_mcount", mispredict_count, 32'd0);
        for (int n = 0; n < 64; n++) begin
            look(rand_pc()); upd(rand_pc(), 1'b1, rand_tgt(), 1'b0, 32'h0);
            step(1'b1);
        end
        idle();
        step(1'b1);
        chk("midsweep_ready", 32'(ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
